// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: command-side controller for the calculator's operand
// memory. It pops one or two operands, computes a result, pushes it back and
// reports completion, underflow or overflow.
module stack_op_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_mode,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              mem_push,
  output logic              mem_pop,
  output logic              mem_stack_queue,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_stack_out,
  input  logic [DATA_W-1:0] mem_queue_out,
  input  logic              mem_empty,
  input  logic              mem_full,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  typedef enum logic [2:0] {IDLE, POP1, POP2, PUSH, DONE} state_t;

  state_t              state_r, state_s;
  logic [2:0]          op_r;
  logic                mode_r;
  logic [DATA_W-1:0]   data_r;
  logic [DATA_W-1:0]   x_r;
  logic [DATA_W-1:0]   y_r;
  logic [DATA_W-1:0]   result_r;
  logic [1:0]          err_code_r;
  logic                mem_push_s;
  logic                mem_pop_s;
  logic [DATA_W-1:0]   pop_word_s;
  logic [DATA_W-1:0]   lhs_s;
  logic [DATA_W-1:0]   rhs_s;
  logic [DATA_W-1:0]   push_val_s;

  // Result = L op R; arithmetic wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] l,
                                            input logic [DATA_W-1:0] r);
    logic [DATA_W-1:0] v;
    case (op)
      OP_ADD:  v = l + r;
      OP_SUB:  v = l - r;
      OP_MUL:  v = l * r;
      OP_AND:  v = l & r;
      OP_OR:   v = l | r;
      OP_XOR:  v = l ^ r;
      default: v = {DATA_W{1'b0}};
    endcase
    return v;
  endfunction

  // Operand selection: the first pop is the later-pushed word in stack mode
  // and the earlier-pushed word in queue mode.
  always_comb begin
    pop_word_s = mode_r ? mem_queue_out : mem_stack_out;
    lhs_s      = mode_r ? x_r : y_r;
    rhs_s      = mode_r ? y_r : x_r;
    push_val_s = (op_r == OP_PUSH) ? data_r : alu(op_r, lhs_s, rhs_s);
  end

  // Next-state and memory strobes; strobes decode from the state register so
  // they fall with the asynchronous reset.
  always_comb begin
    state_s    = state_r;
    mem_push_s = 1'b0;
    mem_pop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          state_s = (cmd_op == OP_PUSH) ? PUSH : POP1;
        end else begin
          state_s = IDLE;
        end
      end
      POP1: begin
        if (mem_empty) begin
          state_s = DONE;
        end else begin
          mem_pop_s = 1'b1;
          state_s   = (op_r == OP_POP) ? DONE : POP2;
        end
      end
      POP2: begin
        if (mem_empty) begin
          state_s = DONE;
        end else begin
          mem_pop_s = 1'b1;
          state_s   = PUSH;
        end
      end
      PUSH: begin
        if (mem_full) begin
          mem_push_s = 1'b0;
        end else begin
          mem_push_s = 1'b1;
        end
        state_s = DONE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched command, operands, result and error code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      op_r       <= 3'b000;
      mode_r     <= 1'b0;
      data_r     <= {DATA_W{1'b0}};
      x_r        <= {DATA_W{1'b0}};
      y_r        <= {DATA_W{1'b0}};
      result_r   <= {DATA_W{1'b0}};
      err_code_r <= ERR_NONE;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            op_r       <= cmd_op;
            mode_r     <= cmd_mode;
            data_r     <= cmd_data;
            err_code_r <= ERR_NONE;
          end
        end
        POP1: begin
          if (mem_empty) begin
            err_code_r <= ERR_UNDER;
          end else begin
            x_r <= pop_word_s;
            if (op_r == OP_POP) begin
              result_r <= pop_word_s;
            end
          end
        end
        POP2: begin
          if (mem_empty) begin
            err_code_r <= ERR_UNDER;
          end else begin
            y_r <= pop_word_s;
          end
        end
        PUSH: begin
          if (mem_full) begin
            err_code_r <= ERR_OVER;
          end else begin
            result_r <= push_val_s;
          end
        end
        default: begin
          op_r <= op_r;
        end
      endcase
    end
  end

  assign cmd_ready       = (state_r == IDLE);
  assign mem_push        = mem_push_s;
  assign mem_pop         = mem_pop_s;
  assign mem_stack_queue = mode_r;
  assign mem_data_in     = mem_push_s ? push_val_s : {DATA_W{1'b0}};
  assign result          = result_r;
  assign result_valid    = (state_r == DONE);
  assign err             = (state_r == DONE) && (err_code_r != ERR_NONE);
  assign err_code        = err_code_r;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Testbench for stack_op_sequencer: behavioural 4-deep stack/queue memory,
// table of directed commands, plus overflow and mid-command reset sequences.
module tb_stack_op_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'b000;
  logic        cmd_mode = 1'b0;
  logic [31:0] cmd_data = 32'd0;
  logic        mem_push, mem_pop, mem_stack_queue;
  logic [31:0] mem_data_in, mem_stack_out, mem_queue_out;
  logic        mem_empty, mem_full;
  logic [31:0] result;
  logic        result_valid, err;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  stack_op_sequencer #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_data(cmd_data),
    .mem_push(mem_push), .mem_pop(mem_pop), .mem_stack_queue(mem_stack_queue),
    .mem_data_in(mem_data_in), .mem_stack_out(mem_stack_out),
    .mem_queue_out(mem_queue_out), .mem_empty(mem_empty), .mem_full(mem_full),
    .result(result), .result_valid(result_valid), .err(err), .err_code(err_code)
  );

  // Behavioural operand memory: entries 0..cnt-1, oldest at index 0.
  logic [31:0] marr [0:3];
  logic [2:0]  mcnt = 3'd0;
  logic        mem_clear = 1'b0;

  always @(posedge clk) begin
    if (mem_clear) begin
      mcnt <= 3'd0;
    end else if (mem_push && mcnt < 3'd4) begin
      marr[mcnt[1:0]] <= mem_data_in;
      mcnt <= mcnt + 3'd1;
    end else if (mem_pop && mcnt > 3'd0) begin
      if (mem_stack_queue) begin
        for (int i = 0; i < 3; i++) marr[i] <= marr[i+1];
      end
      mcnt <= mcnt - 3'd1;
    end
  end

  assign mem_stack_out = (mcnt == 3'd0) ? 32'd0 : marr[mcnt[1:0] - 2'd1];
  assign mem_queue_out = (mcnt == 3'd0) ? 32'd0 : marr[0];
  assign mem_empty     = (mcnt == 3'd0);
  assign mem_full      = (mcnt == 3'd4);

  always @(negedge clk) if (mem_push && mem_pop) overlap++;

  typedef struct {
    logic [2:0]  op;
    logic        mode;
    logic [31:0] data;
    logic [31:0] res;
    logic        e;
    logic [1:0]  code;
    int          lat;
    int          npush;
    int          npop;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] op, input logic mode,
                              input logic [31:0] data, input logic [31:0] res,
                              input logic e, input logic [1:0] code, input int lat,
                              input int npush, input int npop, input int cnt);
    vec_t v;
    v.op = op; v.mode = mode; v.data = data; v.res = res; v.e = e; v.code = code;
    v.lat = lat; v.npush = npush; v.npop = npop; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    @(negedge clk) mem_clear = 1'b1;
    @(negedge clk) mem_clear = 1'b0;
  endtask

  // Issue one command from a negedge and observe it through result_valid.
  task automatic do_cmd(input logic [2:0] op, input logic mode, input logic [31:0] d,
                        output logic [31:0] res, output logic e, output logic [1:0] code,
                        output int lat, output int npush, output int npop,
                        output logic [31:0] pdata);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    cmd_op = op; cmd_mode = mode; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 99; npush = 0; npop = 0; pdata = 32'd0; res = 32'd0; e = 1'b0; code = 2'b11;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_push) begin npush++; pdata = mem_data_in; end
      if (mem_pop) npop++;
      if (result_valid) begin
        lat = c; res = result; e = err; code = err_code;
        break;
      end
    end
  endtask

  logic [31:0] r, pd;
  logic        e;
  logic [1:0]  code;
  int          lat, np, npp;

  initial begin
    // Stack mode basics
    tbl.push_back(mk(3'd0, 1'b0, 32'd5, 32'd5, 1'b0, 2'd0, 2, 1, 0, 1));
    tbl.push_back(mk(3'd0, 1'b0, 32'd3, 32'd3, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd3, 1'b0, 32'd0, 32'd2, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd1, 1'b0, 32'd0, 32'd2, 1'b0, 2'd0, 2, 0, 1, 0));
    // Queue mode
    tbl.push_back(mk(3'd0, 1'b1, 32'd5, 32'd5, 1'b0, 2'd0, 2, 1, 0, 1));
    tbl.push_back(mk(3'd0, 1'b1, 32'd3, 32'd3, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd3, 1'b1, 32'd0, 32'd2, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd1, 1'b1, 32'd0, 32'd2, 1'b0, 2'd0, 2, 0, 1, 0));
    tbl.push_back(mk(3'd0, 1'b1, 32'd7, 32'd7, 1'b0, 2'd0, 2, 1, 0, 1));
    tbl.push_back(mk(3'd0, 1'b1, 32'd4, 32'd4, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd4, 1'b1, 32'd0, 32'd28, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd1, 1'b1, 32'd0, 32'd28, 1'b0, 2'd0, 2, 0, 1, 0));
    // Underflow: empty, then one entry
    tbl.push_back(mk(3'd2, 1'b0, 32'd0, 32'd28, 1'b1, 2'd1, 2, 0, 0, 0));
    tbl.push_back(mk(3'd0, 1'b0, 32'd6, 32'd6, 1'b0, 2'd0, 2, 1, 0, 1));
    tbl.push_back(mk(3'd2, 1'b0, 32'd0, 32'd6, 1'b1, 2'd1, 3, 0, 1, 0));
    // Wrap-around arithmetic
    tbl.push_back(mk(3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2'd0, 2, 1, 0, 1));
    tbl.push_back(mk(3'd0, 1'b0, 32'd1, 32'd1, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd2, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 2, 0, 1, 0));
    tbl.push_back(mk(3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 2, 1, 0, 1));
    tbl.push_back(mk(3'd0, 1'b0, 32'd1, 32'd1, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd3, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd1, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 2'd0, 2, 0, 1, 0));
    tbl.push_back(mk(3'd0, 1'b0, 32'h10000, 32'h10000, 1'b0, 2'd0, 2, 1, 0, 1));
    tbl.push_back(mk(3'd0, 1'b0, 32'h10000, 32'h10000, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd4, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd1, 1'b0, 32'd0, 32'd0, 1'b0, 2'd0, 2, 0, 1, 0));
    // Operand order in stack mode and logic ops
    tbl.push_back(mk(3'd0, 1'b0, 32'd3, 32'd3, 1'b0, 2'd0, 2, 1, 0, 1));
    tbl.push_back(mk(3'd0, 1'b0, 32'd10, 32'd10, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd3, 1'b0, 32'd0, 32'hFFFFFFF9, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd1, 1'b0, 32'd0, 32'hFFFFFFF9, 1'b0, 2'd0, 2, 0, 1, 0));
    tbl.push_back(mk(3'd0, 1'b0, 32'hF0F0, 32'hF0F0, 1'b0, 2'd0, 2, 1, 0, 1));
    tbl.push_back(mk(3'd0, 1'b0, 32'hFF00, 32'hFF00, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd5, 1'b0, 32'd0, 32'hF000, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd0, 1'b0, 32'h0F0F, 32'h0F0F, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd6, 1'b0, 32'd0, 32'hFF0F, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd0, 1'b0, 32'hFFFF, 32'hFFFF, 1'b0, 2'd0, 2, 1, 0, 2));
    tbl.push_back(mk(3'd7, 1'b0, 32'd0, 32'h00F0, 1'b0, 2'd0, 4, 1, 2, 1));
    tbl.push_back(mk(3'd1, 1'b0, 32'd0, 32'h00F0, 1'b0, 2'd0, 2, 0, 1, 0));

    // Reset state
    mem_clear = 1'b1;
    repeat (2) @(negedge clk);
    mem_clear = 1'b0;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_push", {31'd0, mem_push}, 32'd0);
    chk("rst_pop", {31'd0, mem_pop}, 32'd0);
    chk("rst_mode", {31'd0, mem_stack_queue}, 32'd0);
    chk("rst_din", mem_data_in, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven commands
    foreach (tbl[i]) begin
      do_cmd(tbl[i].op, tbl[i].mode, tbl[i].data, r, e, code, lat, np, npp, pd);
      chk($sformatf("v%0d_result", i), r, tbl[i].res);
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, tbl[i].e});
      chk($sformatf("v%0d_code", i), {30'd0, code}, {30'd0, tbl[i].code});
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_npush", i), np, tbl[i].npush);
      chk($sformatf("v%0d_npop", i), npp, tbl[i].npop);
      chk($sformatf("v%0d_cnt", i), {29'd0, mcnt}, tbl[i].cnt);
      if (tbl[i].npush == 1) chk($sformatf("v%0d_pushdata", i), pd, tbl[i].res);
    end

    // Overflow: fill to 4 entries, then PUSH 9 must be refused
    for (int k = 1; k <= 4; k++) begin
      do_cmd(3'd0, 1'b0, k, r, e, code, lat, np, npp, pd);
      chk("fill_result", r, k);
    end
    chk("fill_full", {31'd0, mem_full}, 32'd1);
    do_cmd(3'd0, 1'b0, 32'd9, r, e, code, lat, np, npp, pd);
    chk("ovf_err", {31'd0, e}, 32'd1);
    chk("ovf_code", {30'd0, code}, 32'd2);
    chk("ovf_npush", np, 0);
    chk("ovf_lat", lat, 2);
    chk("ovf_result", r, 32'd4);
    chk("ovf_cnt", {29'd0, mcnt}, 32'd4);
    chk("ovf_top", marr[3], 32'd4);
    repeat (2) @(negedge clk);
    chk("ovf_code_held", {30'd0, err_code}, 32'd2);
    chk("ovf_err_pulse", {31'd0, err}, 32'd0);
    do_cmd(3'd1, 1'b0, 32'd0, r, e, code, lat, np, npp, pd);
    chk("after_ovf_pop", r, 32'd4);
    chk("after_ovf_code", {30'd0, code}, 32'd0);
    clear_mem();

    // Reset during POP2 of an ADD
    do_cmd(3'd0, 1'b0, 32'd1, r, e, code, lat, np, npp, pd);
    do_cmd(3'd0, 1'b0, 32'd2, r, e, code, lat, np, npp, pd);
    @(negedge clk);
    cmd_op = 3'd2; cmd_mode = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pop2_pop", {31'd0, mem_pop}, 32'd1);
    chk("pop2_ready", {31'd0, cmd_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_pop", {31'd0, mem_pop}, 32'd0);
    chk("arst_push", {31'd0, mem_push}, 32'd0);
    chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_result", result, 32'd0);
    chk("arst_valid", {31'd0, result_valid}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_code", {30'd0, err_code}, 32'd0);
    chk("arst_din", mem_data_in, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_cnt", {29'd0, mcnt}, 32'd1);
    do_cmd(3'd0, 1'b0, 32'd1, r, e, code, lat, np, npp, pd);
    chk("post_rst_push", r, 32'd1);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_cnt2", {29'd0, mcnt}, 32'd2);

    chk("push_pop_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
